// File: rtl/pc_fetch_pkg.sv
// Shared encodings for the PC/fetch sequencer: next-PC selects, FSM states and fixed vectors.
`timescale 1ns/1ps
package pc_fetch_pkg;
  localparam logic [1:0]  PC_SEQ  = 2'b00;
  localparam logic [1:0]  PC_BR   = 2'b01;
  localparam logic [1:0]  PC_JAL  = 2'b10;
  localparam logic [1:0]  PC_JALR = 2'b11;

  localparam logic [1:0]  IDLE    = 2'b00;
  localparam logic [1:0]  FETCH   = 2'b01;
  localparam logic [1:0]  EXEC    = 2'b10;

  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0004;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction
endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC target selection with misalignment detection.
`timescale 1ns/1ps
module pc_next_logic
  import pc_fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_sel,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1,
  output logic [31:0] next_pc,
  output logic        misaligned
);
  // Target mux; JALR clears bit 0 before the alignment test.
  always_comb begin
    next_pc = pc + 32'd4;
    case (pc_sel)
      PC_SEQ:  next_pc = pc + 32'd4;
      PC_BR: begin
        if (branch_taken) next_pc = pc + imm;
        else              next_pc = pc + 32'd4;
      end
      PC_JAL:  next_pc = pc + imm;
      PC_JALR: next_pc = (rs1 + imm) & ~32'h0000_0001;
      default: next_pc = pc + 32'd4;
    endcase
    misaligned = is_misaligned(next_pc);
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// Architectural PC register and IDLE/FETCH/EXEC fetch sequencer for the multi-cycle core.
`timescale 1ns/1ps
module pc_fetch_unit
  import pc_fetch_pkg::*;
(
  input  logic        PCU_Clk,
  input  logic        PCU_Reset,
  input  logic        PCU_Advance,
  input  logic        PCU_Stall,
  input  logic [1:0]  PCU_PcSel,
  input  logic        PCU_BranchTaken,
  input  logic [31:0] PCU_Imm,
  input  logic [31:0] PCU_Rs1,
  input  logic        PCU_IfAck,
  input  logic [31:0] PCU_IfData,
  output logic        PCU_IfReq,
  output logic [31:0] PCU_IfAddr,
  output logic [31:0] PCU_Pc,
  output logic [31:0] PCU_PcPlus4,
  output logic [31:0] PCU_Instr,
  output logic        PCU_InstrValid,
  output logic        PCU_Misaligned
);
  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic        if_req_r;
  logic        instr_valid_r;
  logic        misaligned_r;
  logic [31:0] next_pc_s;
  logic        next_mis_s;

  pc_next_logic u_next (
    .pc           (pc_r),
    .pc_sel       (PCU_PcSel),
    .branch_taken (PCU_BranchTaken),
    .imm          (PCU_Imm),
    .rs1          (PCU_Rs1),
    .next_pc      (next_pc_s),
    .misaligned   (next_mis_s)
  );

  // Sequencer; IfReq is registered so it rises together with entry into FETCH.
  always_ff @(posedge PCU_Clk) begin
    if (!PCU_Reset) begin
      state_r       <= IDLE;
      pc_r          <= RESET_VECTOR;
      instr_r       <= NOP;
      if_req_r      <= 1'b0;
      instr_valid_r <= 1'b0;
      misaligned_r  <= 1'b0;
    end else begin
      misaligned_r <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r  <= FETCH;
          if_req_r <= 1'b1;
        end
        FETCH: begin
          if (PCU_IfAck) begin
            instr_r       <= PCU_IfData;
            instr_valid_r <= 1'b1;
            if_req_r      <= 1'b0;
            state_r       <= EXEC;
          end
        end
        EXEC: begin
          if (PCU_Advance && !PCU_Stall) begin
            pc_r          <= next_mis_s ? TRAP_VECTOR : next_pc_s;
            misaligned_r  <= next_mis_s;
            instr_valid_r <= 1'b0;
            if_req_r      <= 1'b1;
            state_r       <= FETCH;
          end
        end
        default: begin
          state_r       <= IDLE;
          if_req_r      <= 1'b0;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign PCU_IfReq      = if_req_r;
  assign PCU_IfAddr     = pc_r;
  assign PCU_Pc         = pc_r;
  assign PCU_PcPlus4    = pc_r + 32'd4;
  assign PCU_Instr      = instr_r;
  assign PCU_InstrValid = instr_valid_r;
  assign PCU_Misaligned = misaligned_r;
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the multi-cycle RISC-V core. It holds the architectural PC and issues a request/acknowledge fetch to instruction memory. It presents the fetched instruction to decode, then advances the PC on the one-cycle strobe from the PC set-enable generator. It sits directly downstream of that generator and upstream of decode/execute.

## Interface
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0004: PC loaded when a computed target is misaligned.
- PCU_Clk  in  1  single clock; all state updates on the rising edge.
- PCU_Reset  in  1  reset, synchronous, active-low.
- PCU_Advance  in  1  one-cycle PC set-enable strobe from the enable generator.
- PCU_Stall  in  1  hazard hold; suppresses Advance.
- PCU_PcSel  in  2  next-PC source: 00 sequential, 01 branch, 10 JAL, 11 JALR.
- PCU_BranchTaken  in  1  branch condition result; used only when PcSel=01.
- PCU_Imm  in  32  sign-extended immediate.
- PCU_Rs1  in  32  rs1 operand for JALR.
- PCU_IfAck  in  1  instruction memory acknowledge; PCU_IfData is valid in the same cycle.
- PCU_IfData  in  32  fetched instruction word.
- PCU_IfReq  out  1  fetch request.
- PCU_IfAddr  out  32  fetch address; always equal to PCU_Pc.
- PCU_Pc  out  32  current PC.
- PCU_PcPlus4  out  32  PCU_Pc+4, used by decode for the JAL/JALR link.
- PCU_Instr  out  32  latched instruction.
- PCU_InstrValid  out  1  PCU_Instr is valid for the current PC.
- PCU_Misaligned  out  1  one-cycle pulse: the computed target had bits [1:0] != 0.

## Operation
- States: IDLE, FETCH, EXEC.
- Reset, while PCU_Reset=0 on an edge:
  - state=IDLE, Pc=RESET_VECTOR, Instr=32'h0000_0013 (NOP).
  - IfReq=0, InstrValid=0, Misaligned=0.
- IDLE: unconditional transition to FETCH on the next edge.
- FETCH:
  - IfReq=1 and IfAddr=Pc, held stable until IfAck is sampled high.
  - On IfAck: Instr<=IfData, InstrValid<=1, go to EXEC.
  - Advance in FETCH is ignored and is not remembered.
- EXEC:
  - InstrValid=1; waits for Advance=1 with Stall=0.
  - On that event: Pc<=next, InstrValid<=0, go to FETCH.
  - Advance and Stall in the same cycle: Stall wins and the state holds.
- Next-PC computation, all arithmetic mod 2^32 (wraps silently):
  - 00: Pc+4.
  - 01: Pc+Imm if BranchTaken, else Pc+4.
  - 10: Pc+Imm.
  - 11: (Rs1+Imm) & ~32'h1.
- Misalignment:
  - Condition: next[1:0] != 0 after JALR bit-0 clearing.
  - Response: Pc<=TRAP_VECTOR instead of next, and Misaligned pulses high for exactly the cycle after the advancing edge.
  - Sequential path: never misaligned while Pc stays aligned.
- Reset mid-FETCH: IfReq drops on the next edge and the outstanding fetch is abandoned. An IfAck arriving in IDLE is ignored.
- IfReq is never asserted in EXEC or IDLE.

## Timing
- Reset release at edge R: FETCH active from R+1, so IfReq=1 during cycle R+1.
- Zero-wait memory (IfAck in the first request cycle): InstrValid=1 one cycle after request start.
- Advance sampled at edge N in EXEC:
  - Pc updated and visible after N.
  - IfReq high in cycle N+1.
  - InstrValid low from N+1 until the ack edge.
- Minimum loop: 2 cycles per instruction (FETCH 1, EXEC 1). This matches an every-other-cycle Advance.
- Outputs are registered except IfAddr/PcPlus4, which derive combinationally from Pc only.

## Structure
- Package pc_fetch_pkg holds:
  - PcSel encodings: PC_SEQ, PC_BR, PC_JAL, PC_JALR.
  - State encoding: IDLE, FETCH, EXEC.
  - The NOP constant.
- Sub-module pc_next_logic: purely combinational.
  - Inputs: Pc, PcSel, BranchTaken, Imm, Rs1.
  - Outputs: next target and misaligned flag.
  - Instantiated once; the FSM and registers stay in pc_fetch_unit.

## Test plan
- Reset then release, IfAck held 1, IfData=32'h00500093:
  - IfAddr=0 in cycle R+1.
  - Instr=32'h00500093 and InstrValid=1 at R+2.
  - Misaligned=0 throughout.
- EXEC with PcSel=01, BranchTaken=1, Imm=-8, Pc=0x100, Advance=1: Pc=0xF8, IfReq=1 next cycle. Repeat with BranchTaken=0: Pc=0x104.
- PcSel=11, Rs1=0x203, Imm=0: Pc=0x202, which is misaligned, so Pc=TRAP_VECTOR and Misaligned pulses for exactly one cycle.
- Advance and Stall together for 3 cycles, then Advance alone: Pc unchanged for 3 cycles, then Pc+4. Advance during FETCH is dropped.
- IfAck delayed 5 cycles: IfReq and IfAddr are stable for all 6 request cycles and InstrValid stays low. Pulsing reset low in the 3rd request cycle gives IfReq=0 and Pc=RESET_VECTOR.
- Pc=0xFFFF_FFFC with sequential Advance: Pc wraps to 0x0000_0000 with no Misaligned pulse.
